// File: rtl/aes_dec_feeder_if.sv
// aes_dec_feeder_if
//   Ciphertext block stream into the AES decryption feeder.
//   s_data  : 128-bit ciphertext block
//   s_valid : s_data is valid this cycle
//   s_ready : receiver can accept a block this cycle
//   master  : block source (drives data/valid, reads ready)
//   slave   : aes_dec_feeder (reads data/valid, drives ready)
interface aes_dec_feeder_if;
  logic [127:0] s_data;
  logic         s_valid;
  logic         s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/aes_dec_feeder.sv
// aes_dec_feeder
//   Input sequencer in front of a pipelined AES decryption core. It latches
//   a cipher key, pulses the core's key-expansion start (dec_fsm_en), waits
//   KEY_WAIT cycles for expansion to complete, then drains a small
//   ciphertext FIFO into the core at up to one block per cycle.
//
//   Parameters
//     KEY_WAIT   : idle cycles after the fsm_en pulse before issue (>= 1)
//     FIFO_DEPTH : ciphertext FIFO entries (power of two, >= 2)
//   Ports
//     clk        : rising-edge clock
//     rst        : asynchronous active-low reset
//     key_in     : new cipher key
//     key_load   : latch key_in and restart key expansion
//     s          : ciphertext block stream (slave side)
//     dec_in     : block presented to the core
//     dec_key    : key presented to the core
//     dec_enable : one-cycle strobe per issued block
//     dec_fsm_en : one-cycle key-expansion start strobe
//     key_ready  : high while blocks may issue (RUN)
//     blk_count  : blocks issued, wraps at 16 bits
module aes_dec_feeder #(
  parameter int KEY_WAIT   = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [127:0]      key_in,
  input  logic              key_load,
  aes_dec_feeder_if.slave   s,
  output logic [127:0]      dec_in,
  output logic [127:0]      dec_key,
  output logic              dec_enable,
  output logic              dec_fsm_en,
  output logic              key_ready,
  output logic [15:0]       blk_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (KEY_WAIT > 1) ? $clog2(KEY_WAIT) : 1;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(KEY_WAIT - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   LVL_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KSTART = 2'd1,
    KWAIT  = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  logic             pop;

  logic [127:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   level;
  logic             full, empty, push;

  assign full      = (level == FIFO_FULL);
  assign empty     = (level == '0);
  // No bypass: a full FIFO refuses input even when it pops on the same edge.
  assign s.s_ready = !full;
  assign push      = s.s_valid && !full;

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    pop       = 1'b0;
    unique case (state)
      IDLE:   ;
      KSTART: begin
        state_nxt = KWAIT;
        wait_nxt  = '0;
      end
      KWAIT: begin
        if (wait_cnt == WAIT_LAST) state_nxt = RUN;
        else                       wait_nxt  = wait_cnt + CNT_ONE;
      end
      RUN:    pop = !empty;
    endcase
    // A key load wins from every state and cancels any issue on this edge;
    // queued blocks stay put and go out under the new key.
    if (key_load) begin
      state_nxt = KSTART;
      pop       = 1'b0;
    end
  end

  // Control state and registered outputs (all derived from next state so
  // they line up exactly with the state they describe).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      dec_fsm_en <= 1'b0;
      key_ready  <= 1'b0;
      dec_enable <= 1'b0;
      dec_in     <= '0;
      dec_key    <= '0;
      blk_count  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      dec_fsm_en <= (state_nxt == KSTART);
      key_ready  <= (state_nxt == RUN);
      dec_enable <= pop;
      if (key_load) dec_key <= key_in;
      if (pop) begin
        dec_in    <= mem[rd_ptr];
        blk_count <= blk_count + 16'd1;
        rd_ptr    <= rd_ptr + PTR_ONE;
      end
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // FIFO storage: contents are don't-care while the level is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s.s_data;
  end

endmodule

// File: tb/tb_aes_dec_feeder.sv
module tb_aes_dec_feeder;
  localparam int KW    = 10;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_load;
  logic [127:0] dec_in, dec_key;
  logic         dec_enable, dec_fsm_en, key_ready;
  logic [15:0]  blk_count;

  aes_dec_feeder_if sif ();

  aes_dec_feeder #(.KEY_WAIT(KW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_load   (key_load),
    .s          (sif),
    .dec_in     (dec_in),
    .dec_key    (dec_key),
    .dec_enable (dec_enable),
    .dec_fsm_en (dec_fsm_en),
    .key_ready  (key_ready),
    .blk_count  (blk_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: a queue of accepted blocks plus the edge number of
  // the most recent key load. Blocks may issue on edges at least KW+2 after
  // the load edge; key_ready is high from edge KW+1 after it.
  int           n = 0;
  int           kl_edge = 0;
  bit           has_key = 0;
  logic [127:0] mq [$];
  logic [127:0] m_in, m_key;
  logic         m_en, m_fsm, m_rdy;
  logic [15:0]  m_cnt;

  // Observations for the literal timing checks.
  int fsm_cnt = 0, last_fsm_edge = 0, en_cnt = 0, first_en_edge = -1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    has_key = 0;
    m_in = '0; m_key = '0; m_en = 0; m_fsm = 0; m_rdy = 0; m_cnt = '0;
  endtask

  task automatic compare_all();
    chk("dec_in",     dec_in,     m_in);
    chk("dec_key",    dec_key,    m_key);
    chk("dec_enable", dec_enable, m_en);
    chk("dec_fsm_en", dec_fsm_en, m_fsm);
    chk("key_ready",  key_ready,  m_rdy);
    chk("blk_count",  blk_count,  m_cnt);
    chk("s_ready",    sif.s_ready, (mq.size() != DEPTH));
  endtask

  task automatic cycle();
    bit full, push, pop;
    @(posedge clk);
    n++;
    full = (mq.size() == DEPTH);
    push = sif.s_valid && !full;
    pop  = has_key && !key_load && (n >= kl_edge + KW + 2) && (mq.size() > 0);
    m_en = pop;
    if (pop) begin
      m_in  = mq.pop_front();
      m_cnt = m_cnt + 16'd1;
    end
    if (push) mq.push_back(sif.s_data);
    m_fsm = key_load;
    if (key_load) begin
      kl_edge = n;
      has_key = 1;
      m_key   = key_in;
    end
    m_rdy = has_key && !key_load && (n >= kl_edge + KW + 1);
    @(negedge clk);
    compare_all();
    if (dec_fsm_en) begin fsm_cnt++; last_fsm_edge = n; end
    if (dec_enable) begin
      en_cnt++;
      if (first_en_edge < 0) first_en_edge = n;
    end
  endtask

  task automatic step(input bit kl, input logic [127:0] k, input bit v, input logic [127:0] d);
    key_load    = kl;
    key_in      = k;
    sif.s_valid = v;
    sif.s_data  = d;
    cycle();
    key_load    = 1'b0;
    sif.s_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, key_in, 0, '0);
  endtask

  task automatic wait_en(input string name, input int bound);
    int i;
    i = 0;
    while (dec_enable !== 1'b1 && i < bound) begin
      step(0, key_in, 0, '0);
      i++;
    end
    chk({name, " enable seen"}, dec_enable, 1'b1);
  endtask

  task automatic wait_rdy(input string name, input int bound);
    int i;
    i = 0;
    while (key_ready !== 1'b1 && i < bound) begin
      step(0, key_in, 0, '0);
      i++;
    end
    chk({name, " key_ready seen"}, key_ready, 1'b1);
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    int fsm0, en0, burst, loops;
    logic [127:0] blk [4];
    logic [15:0]  wrap_exp [3];
    wrap_exp[0] = 16'hFFFF; wrap_exp[1] = 16'h0000; wrap_exp[2] = 16'h0001;

    rst = 1'b0; key_load = 1'b0; key_in = '0;
    sif.s_valid = 1'b0; sif.s_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset dec_in",     dec_in,      128'h0);
    chk("reset dec_key",    dec_key,     128'h0);
    chk("reset blk_count",  blk_count,   16'h0);
    chk("reset dec_enable", dec_enable,  1'b0);
    chk("reset dec_fsm_en", dec_fsm_en,  1'b0);
    chk("reset key_ready",  key_ready,   1'b0);
    chk("reset s_ready",    sif.s_ready, 1'b1);
    rst = 1'b1;
    idle(2);

    // Basic decrypt
    fsm0 = fsm_cnt; first_en_edge = -1;
    step(1, K1, 0, '0);
    step(0, K1, 1, C1);
    wait_en("basic", 30);
    chk("basic fsm pulses", fsm_cnt - fsm0, 1);
    chk("basic latency",    first_en_edge - (last_fsm_edge + 1), 11);
    chk("basic dec_in",     dec_in,    C1);
    chk("basic blk_count",  blk_count, 16'd1);
    chk("basic dec_key",    dec_key,   K1);
    idle(2);

    // Hold-off: four pushes during KWAIT
    for (int j = 0; j < 4; j++) blk[j] = {4{32'hB0000000 + 32'(j)}};
    en0 = en_cnt;
    step(1, 128'h2222_0000_0000_0000_0000_0000_0000_0002, 0, '0);
    idle(1);
    for (int j = 0; j < 4; j++) step(0, key_in, 1, blk[j]);
    chk("hold s_ready full", sif.s_ready, 1'b0);
    wait_rdy("hold", 30);
    chk("hold no early enable", en_cnt - en0, 0);
    wait_en("hold", 5);
    burst = 0;
    while (dec_enable === 1'b1 && burst < 10) begin
      burst++;
      if (burst == 4) chk("hold last dec_in", dec_in, blk[3]);
      step(0, key_in, 0, '0);
    end
    chk("hold burst length", burst, 4);
    chk("hold s_ready back", sif.s_ready, 1'b1);
    chk("hold blk_count",    blk_count, 16'd5);

    // Reload mid-stream with two blocks queued
    for (int j = 0; j < 4; j++) blk[j] = {4{32'hD0000000 + 32'(j)}};
    step(1, 128'h3333_0000_0000_0000_0000_0000_0000_0003, 0, '0);
    idle(1);
    for (int j = 0; j < 4; j++) step(0, key_in, 1, blk[j]);
    wait_rdy("reload", 30);
    idle(2);
    chk("reload pre dec_in", dec_in, blk[1]);
    first_en_edge = -1;
    step(1, 128'h4444_0000_0000_0000_0000_0000_0000_0004, 0, '0);
    chk("reload issue stops", dec_enable, 1'b0);
    chk("reload fsm_en",      dec_fsm_en, 1'b1);
    wait_en("reload", 30);
    chk("reload latency",  first_en_edge - (last_fsm_edge + 1), 11);
    chk("reload new key",  dec_key, 128'h4444_0000_0000_0000_0000_0000_0000_0004);
    chk("reload dec_in 2", dec_in,  blk[2]);
    step(0, key_in, 0, '0);
    chk("reload dec_in 3", dec_in,  blk[3]);
    step(0, key_in, 0, '0);
    chk("reload drained",   dec_enable, 1'b0);
    chk("reload blk_count", blk_count, 16'd9);

    // Back-to-back reload during KWAIT
    fsm0 = fsm_cnt; first_en_edge = -1;
    step(1, 128'h5555_0000_0000_0000_0000_0000_0000_0005, 0, '0);
    idle(1);
    step(0, key_in, 1, 128'hE0E0_E0E0_E0E0_E0E0_E0E0_E0E0_E0E0_E0E0);
    idle(4);
    step(1, 128'h6666_0000_0000_0000_0000_0000_0000_0006, 0, '0);
    wait_en("b2b", 30);
    chk("b2b fsm pulses", fsm_cnt - fsm0, 2);
    chk("b2b latency",    first_en_edge - (last_fsm_edge + 1), 11);
    chk("b2b dec_key",    dec_key, 128'h6666_0000_0000_0000_0000_0000_0000_0006);
    chk("b2b blk_count",  blk_count, 16'd10);

    // Async reset with a full FIFO
    step(1, 128'h7777_0000_0000_0000_0000_0000_0000_0007, 0, '0);
    idle(1);
    for (int j = 0; j < 4; j++) step(0, key_in, 1, {4{32'hF0000000 + 32'(j)}});
    chk("areset pre full", sif.s_ready, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("areset dec_in",     dec_in,      128'h0);
    chk("areset dec_key",    dec_key,     128'h0);
    chk("areset blk_count",  blk_count,   16'h0);
    chk("areset key_ready",  key_ready,   1'b0);
    chk("areset s_ready",    sif.s_ready, 1'b1);
    compare_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    en0 = en_cnt;
    step(0, key_in, 1, 128'hABCD_0000_0000_0000_0000_0000_0000_0001);
    idle(20);
    chk("areset no enable", en_cnt - en0, 0);

    // Counter wrap: stream until 0xFFFE, then three single blocks
    step(1, 128'h8888_0000_0000_0000_0000_0000_0000_0008, 0, '0);
    loops = 0;
    while ((int'(m_cnt) + mq.size() < 65534) && loops < 70000) begin
      step(0, key_in, 1, {96'h0, 32'(loops)});
      loops++;
    end
    loops = 0;
    while (blk_count !== 16'hFFFE && loops < 20) begin
      step(0, key_in, 0, '0);
      loops++;
    end
    chk("wrap preload", blk_count, 16'hFFFE);
    for (int j = 0; j < 3; j++) begin
      step(0, key_in, 1, {4{32'hC0000000 + 32'(j)}});
      wait_en("wrap", 5);
      chk("wrap blk_count", blk_count, wrap_exp[j]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
